// File: rtl/game_pkg.sv
// Shared game-side constants and types: coordinate/colour widths, screen size,
// and the obstacle FSM state set.
package game_pkg;

    localparam int unsigned COORD_W       = 11;
    localparam int unsigned COLOUR_W      = 3;
    localparam int unsigned SCREEN_WIDTH  = 160;
    localparam int unsigned SCREEN_HEIGHT = 120;

    typedef logic [COORD_W-1:0]  coord_t;
    typedef logic [COLOUR_W-1:0] colour_t;

    localparam colour_t BLACK = '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_MOVE,
        S_DRAW,
        S_DONE
    } state_t;

endpackage

// File: rtl/rect_raster.sv
// Raster counter for a WIDTH x HEIGHT rectangle: dx runs fastest, dy steps on
// each dx wrap, and both return to zero after the last pixel.
module rect_raster #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned HEIGHT = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       advance,
    output logic [3:0] dx,
    output logic [3:0] dy,
    output logic       last
);

    localparam logic [3:0] DX_MAX = 4'(WIDTH - 1);
    localparam logic [3:0] DY_MAX = 4'(HEIGHT - 1);

    assign last = (dx == DX_MAX) && (dy == DY_MAX);

    always_ff @(posedge clock) begin
        if (reset || start) begin
            dx <= '0;
            dy <= '0;
        end else if (advance) begin
            if (dx == DX_MAX) begin
                dx <= '0;
                dy <= (dy == DY_MAX) ? '0 : dy + 4'd1;
            end else begin
                dx <= dx + 4'd1;
            end
        end
    end

endmodule

// File: rtl/scrolling_block.sv
// One scrolling obstacle: on each draw request it streams its pixels (erasing
// and shifting left first if a frame tick is pending) and flags when it has left.
module scrolling_block
    import game_pkg::*;
#(
    parameter logic [10:0] START_X  = 11'd160,
    parameter logic [10:0] START_Y  = 11'd100,
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned HEIGHT   = 4,
    parameter logic [2:0]  COLOUR   = 3'b010,
    parameter int unsigned STEP     = 1,
    parameter int unsigned SCREEN_W = SCREEN_WIDTH
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        draw_start,
    input  logic        update_screen,
    output logic [10:0] send_x,
    output logic [10:0] send_y,
    output logic [2:0]  send_colour,
    output logic        draw_done,
    output logic [10:0] shape_gone
);

    state_t     state;
    state_t     next_state;
    coord_t     pos_x;
    logic       pending;
    logic       gone;
    logic [3:0] dx;
    logic [3:0] dy;
    logic       raster_last;
    logic       raster_start;
    logic       raster_advance;
    logic       off_screen;
    logic [11:0] pixel_x;
    logic [11:0] reach;

    assign raster_start   = (state == S_IDLE) || (state == S_MOVE) || (state == S_DONE);
    assign raster_advance = (state == S_ERASE) || (state == S_DRAW);

    rect_raster #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_raster (
        .clock   (clock),
        .reset   (reset),
        .start   (raster_start),
        .advance (raster_advance),
        .dx      (dx),
        .dy      (dy),
        .last    (raster_last)
    );

    // Gone test runs before the subtraction; the pos_x < STEP term keeps the
    // 11-bit position from ever wrapping below zero.
    assign reach      = {1'b0, pos_x} + 12'(STEP);
    assign off_screen = (reach <= 12'(WIDTH)) || (pos_x < 11'(STEP));
    assign pixel_x    = {1'b0, pos_x} + {8'd0, dx};

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE: begin
                if (draw_start) begin
                    if (gone)
                        next_state = S_DONE;
                    else if (pending || update_screen)
                        next_state = S_ERASE;
                    else
                        next_state = S_DRAW;
                end
            end
            S_ERASE: if (raster_last) next_state = S_MOVE;
            S_MOVE:  next_state = off_screen ? S_DONE : S_DRAW;
            S_DRAW:  if (raster_last) next_state = S_DONE;
            S_DONE:  if (!draw_start) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pos_x     <= START_X;
            pending   <= 1'b0;
            gone      <= 1'b0;
            draw_done <= 1'b0;
        end else begin
            draw_done <= (next_state == S_DONE);
            if (state == S_MOVE) begin
                pending <= update_screen;
                if (off_screen)
                    gone <= 1'b1;
                else
                    pos_x <= pos_x - 11'(STEP);
            end else begin
                pending <= pending | update_screen;
            end
        end
    end

    always_comb begin
        send_x      = pixel_x[10:0];
        send_y      = START_Y + {7'd0, dy};
        send_colour = BLACK;
        if (state == S_DRAW && pixel_x < 12'(SCREEN_W))
            send_colour = COLOUR;
    end

    assign shape_gone = {10'd0, gone};

endmodule
